// File: rtl/game_level_sequencer.sv
// game_level_sequencer: Title -> N levels with intermission -> Win / Game_Over flow controller.
// Generates per-level zombie speed/spawn-delay config arithmetically; all outputs registered (1 cycle).
// Optional pause support is compiled in with `define GAME_LEVEL_SEQUENCER_PAUSE_EN.
module game_level_sequencer #(
  parameter int NUM_LEVELS          = 10,
  parameter int NUM_ZOMBIES         = 3,
  parameter int SPEED_W             = 10,
  parameter int DELAY_W             = 10,
  parameter int HEALTH_W            = 4,
  parameter int ENEMY_W             = 4,
  parameter int BASE_DELAY          = 100,
  parameter int STAGGER             = 100,
  parameter int DELAY_STEP          = 10,
  parameter int MIN_DELAY           = 20,
  parameter int SPEED_SHIFT         = 2,
  parameter int INTERMISSION_CYCLES = 120
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           Play,
  input  logic [ENEMY_W-1:0]             enemies_remaining,
  input  logic [HEALTH_W-1:0]            player_health,
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
  input  logic                           pause,
`endif
  output logic [3:0]                     level,
  output logic [2:0]                     event_screen,
  output logic                           new_level,
  output logic [NUM_ZOMBIES*SPEED_W-1:0] zombie_speed,
  output logic [NUM_ZOMBIES*DELAY_W-1:0] zombie_delay_spawn
);

  // State codes double as the screen-select code driven to the colour mapper.
  localparam logic [2:0] S_TITLE  = 3'd0;
  localparam logic [2:0] S_LEVEL  = 3'd1;
  localparam logic [2:0] S_WIN    = 3'd2;
  localparam logic [2:0] S_GOVER  = 3'd3;
  localparam logic [2:0] S_INTER  = 3'd4;
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
  localparam logic [2:0] S_PAUSED = 3'd5;
`endif

  localparam int CNT_W = (INTERMISSION_CYCLES > 1) ? $clog2(INTERMISSION_CYCLES) : 1;
  localparam int DMAX  = (1 << DELAY_W) - 1;
  localparam int SMAX  = (1 << SPEED_W) - 1;

  logic [2:0]                     r_state;
  logic [3:0]                     r_lvl;
  logic                           r_armed;
  logic                           r_play_q;
  logic [CNT_W-1:0]               r_cnt;
  logic [3:0]                     r_level;
  logic                           r_new_level;
  logic [NUM_ZOMBIES*SPEED_W-1:0] r_speed;
  logic [NUM_ZOMBIES*DELAY_W-1:0] r_delay;

  logic                           w_play_rise;
  logic                           w_pause_rise;
  logic [2:0]                     w_next_state;
  logic [3:0]                     w_next_lvl;
  logic                           w_enter_level;
  logic                           w_in_level_next;
  logic [NUM_ZOMBIES*SPEED_W-1:0] w_speed_next;
  logic [NUM_ZOMBIES*DELAY_W-1:0] w_delay_next;

  // Spawn delay shrinks per level, floored at MIN_DELAY and saturated to the field width.
  function automatic logic [DELAY_W-1:0] f_delay(input int z, input int lvl);
    int d;
    d = BASE_DELAY + z * STAGGER - (lvl - 1) * DELAY_STEP;
    if (d < MIN_DELAY) d = MIN_DELAY;
    if (d > DMAX) d = DMAX;
    return DELAY_W'(d);
  endfunction

  // Speed steps up every 2^SPEED_SHIFT levels; the last zombie is one step faster.
  function automatic logic [SPEED_W-1:0] f_speed(input int z, input int lvl);
    int s;
    s = 1 + ((lvl - 1) >> SPEED_SHIFT) + ((z == NUM_ZOMBIES - 1) ? 1 : 0);
    if (s > SMAX) s = SMAX;
    return SPEED_W'(s);
  endfunction

  assign w_play_rise = Play & ~r_play_q;

`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
  logic r_pause_q;

  // Pause edge detector history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_pause_q <= 1'b0;
    else          r_pause_q <= pause;
  end

  assign w_pause_rise = pause & ~r_pause_q;
`else
  assign w_pause_rise = 1'b0;
`endif

  // Next-state, next-level and level-entry decode.
  always_comb begin
    w_next_state  = r_state;
    w_next_lvl    = r_lvl;
    w_enter_level = 1'b0;
    case (r_state)
      S_TITLE: begin
        if (w_play_rise) begin
          w_next_state  = S_LEVEL;
          w_next_lvl    = 4'd1;
          w_enter_level = 1'b1;
        end
      end
      S_LEVEL: begin
        if (player_health == '0) begin
          w_next_state = S_GOVER;
        end else if (r_armed && (enemies_remaining == '0)) begin
          w_next_state = (r_lvl < 4'(NUM_LEVELS)) ? S_INTER : S_WIN;
        end else if (w_pause_rise) begin
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
          w_next_state = S_PAUSED;
`endif
        end
      end
      S_INTER: begin
        if (r_cnt == '0) begin
          w_next_state  = S_LEVEL;
          w_next_lvl    = r_lvl + 4'd1;
          w_enter_level = 1'b1;
        end
      end
      S_WIN: begin
        if (w_play_rise) w_next_state = S_TITLE;
      end
      S_GOVER: begin
        if (w_play_rise) begin
          w_next_state  = S_LEVEL;
          w_next_lvl    = 4'd1;
          w_enter_level = 1'b1;
        end
      end
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
      S_PAUSED: begin
        if (w_pause_rise) w_next_state = S_LEVEL;
      end
`endif
      default: w_next_state = S_TITLE;
    endcase
  end

`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
  assign w_in_level_next = (w_next_state == S_LEVEL) || (w_next_state == S_PAUSED);
`else
  assign w_in_level_next = (w_next_state == S_LEVEL);
`endif

  // Per-zombie config for the level about to be entered.
  always_comb begin
    w_speed_next = '0;
    w_delay_next = '0;
    for (int z = 0; z < NUM_ZOMBIES; z++) begin
      w_speed_next[z*SPEED_W +: SPEED_W] = f_speed(z, int'(w_next_lvl));
      w_delay_next[z*DELAY_W +: DELAY_W] = f_delay(z, int'(w_next_lvl));
    end
  end

  // State, level bookkeeping, arming and intermission timer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_TITLE;
      r_lvl    <= 4'd0;
      r_armed  <= 1'b0;
      r_play_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_lvl    <= w_next_lvl;
      r_play_q <= Play;
      // Arming waits for the spawner to report live enemies so a reload gap is not a clear.
      if (w_enter_level)
        r_armed <= 1'b0;
      else if ((r_state == S_LEVEL) && (enemies_remaining != '0))
        r_armed <= 1'b1;
      if ((w_next_state == S_INTER) && (r_state != S_INTER))
        r_cnt <= CNT_W'(INTERMISSION_CYCLES - 1);
      else if ((r_state == S_INTER) && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Registered outputs follow the state they describe; config loads on entry, holds in level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_level     <= 4'd0;
      r_new_level <= 1'b0;
      r_speed     <= '0;
      r_delay     <= '0;
    end else begin
      r_new_level <= w_enter_level;
      r_level     <= w_in_level_next ? w_next_lvl : 4'd0;
      if (w_enter_level) begin
        r_speed <= w_speed_next;
        r_delay <= w_delay_next;
      end else if (!w_in_level_next) begin
        r_speed <= '0;
        r_delay <= '0;
      end
    end
  end

  assign level              = r_level;
  assign event_screen       = r_state;
  assign new_level          = r_new_level;
  assign zombie_speed       = r_speed;
  assign zombie_delay_spawn = r_delay;

endmodule

// File: tb/tb_game_level_sequencer.sv
// Directed bench for game_level_sequencer with a short intermission.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_game_level_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Play;
  logic [3:0]  enemies_remaining;
  logic [3:0]  player_health;
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
  logic        pause;
`endif
  logic [3:0]  level;
  logic [2:0]  event_screen;
  logic        new_level;
  logic [29:0] zombie_speed;
  logic [29:0] zombie_delay_spawn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  game_level_sequencer #(.INTERMISSION_CYCLES(4)) dut (
    .Clk                (Clk),
    .Reset_n            (Reset_n),
    .Play               (Play),
    .enemies_remaining  (enemies_remaining),
    .player_health      (player_health),
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
    .pause              (pause),
`endif
    .level              (level),
    .event_screen       (event_screen),
    .new_level          (new_level),
    .zombie_speed       (zombie_speed),
    .zombie_delay_spawn (zombie_delay_spawn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_cfg(input string tag, input int d0, input int d1, input int d2,
                         input int s0, input int s1, input int s2);
    chk({tag, "_d0"}, 32'(zombie_delay_spawn[9:0]),   d0);
    chk({tag, "_d1"}, 32'(zombie_delay_spawn[19:10]), d1);
    chk({tag, "_d2"}, 32'(zombie_delay_spawn[29:20]), d2);
    chk({tag, "_s0"}, 32'(zombie_speed[9:0]),         s0);
    chk({tag, "_s1"}, 32'(zombie_speed[19:10]),       s1);
    chk({tag, "_s2"}, 32'(zombie_speed[29:20]),       s2);
  endtask

  // Arm with live enemies, clear them, then ride out the 4-cycle intermission into the next level.
  task automatic clear_and_advance();
    enemies_remaining = 4'd2; tick();
    enemies_remaining = 4'd0; tick();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    Reset_n = 1'b0; Play = 1'b0; enemies_remaining = 4'd0; player_health = 4'd15;
`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
    pause = 1'b0;
`endif
    #12;
    chk("rst_screen", 32'(event_screen), 0);
    chk("rst_level",  32'(level), 0);
    chk("rst_newlvl", 32'(new_level), 0);
    chk("rst_speed",  32'(zombie_speed), 0);
    chk("rst_delay",  32'(zombie_delay_spawn), 0);
    @(negedge Clk); Reset_n = 1'b1;
    tick(); tick();
    chk("title_idle", 32'(event_screen), 0);

    // Start: level 1 on the edge that sees the Play rise.
    Play = 1'b1; tick();
    chk("l1_screen", 32'(event_screen), 1);
    chk("l1_level",  32'(level), 1);
    chk("l1_newlvl", 32'(new_level), 1);
    chk_cfg("l1", 100, 200, 300, 1, 1, 2);
    Play = 1'b0; tick();
    chk("l1_pulse_end", 32'(new_level), 0);
    tick(); tick(); tick();
    chk("l1_unarmed_stay", 32'(event_screen), 1);

    // Clear level 1 and count intermission cycles.
    enemies_remaining = 4'd2; tick();
    chk("l1_armed_stay", 32'(event_screen), 1);
    enemies_remaining = 4'd0; tick();
    chk("inter_screen", 32'(event_screen), 4);
    chk("inter_level",  32'(level), 0);
    chk("inter_delay",  32'(zombie_delay_spawn), 0);
    player_health = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("inter_hold", 32'(event_screen), 4);
    end
    player_health = 4'd15;
    tick();
    chk("l2_screen", 32'(event_screen), 1);
    chk("l2_level",  32'(level), 2);
    chk("l2_newlvl", 32'(new_level), 1);
    chk_cfg("l2", 90, 190, 290, 1, 1, 2);

    // Climb to the final level.
    for (int l = 2; l < 10; l++) clear_and_advance();
    chk("l10_level",  32'(level), 10);
    chk("l10_newlvl", 32'(new_level), 1);
    chk_cfg("l10", 20, 110, 210, 3, 3, 4);
    enemies_remaining = 4'd2; tick();
    enemies_remaining = 4'd0; tick();
    chk("win_screen", 32'(event_screen), 2);
    chk("win_level",  32'(level), 0);
    Play = 1'b1; tick();
    chk("win_to_title", 32'(event_screen), 0);
    Play = 1'b0; tick();

    // Death and clear in the same cycle: game over wins; held Play does not retry.
    Play = 1'b1; tick();
    chk("go_l1_level", 32'(level), 1);
    enemies_remaining = 4'd2; tick();
    enemies_remaining = 4'd0; player_health = 4'd0; tick();
    chk("go_screen", 32'(event_screen), 3);
    chk("go_delay",  32'(zombie_delay_spawn), 0);
    tick(); tick();
    chk("go_play_held", 32'(event_screen), 3);
    player_health = 4'd15; Play = 1'b0; tick();
    chk("go_no_auto_exit", 32'(event_screen), 3);
    Play = 1'b1; tick();
    chk("retry_screen", 32'(event_screen), 1);
    chk("retry_level",  32'(level), 1);
    chk("retry_newlvl", 32'(new_level), 1);
    Play = 1'b0; tick();

    // Asynchronous reset in the middle of an intermission.
    enemies_remaining = 4'd2; tick();
    enemies_remaining = 4'd0; tick();
    tick();
    chk("pre_rst_inter", 32'(event_screen), 4);
    #2 Reset_n = 1'b0; #1;
    chk("arst_screen", 32'(event_screen), 0);
    chk("arst_level",  32'(level), 0);
    chk("arst_speed",  32'(zombie_speed), 0);
    @(negedge Clk); Reset_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("post_rst_title", 32'(event_screen), 0);
    chk("post_rst_newlvl", 32'(new_level), 0);
    Play = 1'b1; tick();
    chk("post_rst_l1", 32'(level), 1);
    Play = 1'b0; tick();

`ifdef GAME_LEVEL_SEQUENCER_PAUSE_EN
    pause = 1'b1; tick();
    chk("pause_screen", 32'(event_screen), 5);
    chk("pause_level",  32'(level), 1);
    chk_cfg("pause", 100, 200, 300, 1, 1, 2);
    player_health = 4'd0; tick();
    chk("pause_ignore_health", 32'(event_screen), 5);
    player_health = 4'd15; pause = 1'b0; tick();
    pause = 1'b1; tick();
    chk("resume_screen", 32'(event_screen), 1);
    chk("resume_newlvl", 32'(new_level), 0);
    chk("resume_level",  32'(level), 1);
    pause = 1'b0; tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_level_sequencer.md
Name: game_level_sequencer

Overview:
- Parametrised top-level game flow controller: Title → N levels with intermission → Win / Game_Over.
- Generates per-level zombie speed and spawn-delay configuration for NUM_ZOMBIES channels arithmetically, replacing hand-coded per-level tables.
- Sits between the input/keycode logic (Play) and the zombie/player entity blocks.
- Drives the screen-select code consumed by the colour mapper.

Parameters:
- NUM_LEVELS, 10: number of playable levels (1..15).
- NUM_ZOMBIES, 3: zombie channels driven.
- SPEED_W, 10: width of each speed field.
- DELAY_W, 10: width of each spawn-delay field.
- HEALTH_W, 4: player_health width.
- ENEMY_W, 4: enemies_remaining width.
- BASE_DELAY, 100: level-1 spawn delay of zombie 0.
- STAGGER, 100: extra delay per zombie index.
- DELAY_STEP, 10: delay reduction per level.
- MIN_DELAY, 20: delay floor.
- SPEED_SHIFT, 2: speed increases by 1 every 2^SPEED_SHIFT levels.
- INTERMISSION_CYCLES, 120: Clk cycles spent between levels.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Play  in  1  start/continue request, level-sensitive; only its rising edge acts.
- enemies_remaining  in  ENEMY_W  live enemy count from the spawner.
- player_health  in  HEALTH_W  live player health.
- level  out  4  current level 1..NUM_LEVELS; 0 outside a level.
- event_screen  out  3  0 Title, 1 Play, 2 Win, 3 Game_Over, 4 Intermission, 5 Paused.
- new_level  out  1  one-cycle pulse on entry to any level state.
- zombie_speed  out  NUM_ZOMBIES*SPEED_W  packed; zombie z occupies [z*SPEED_W +: SPEED_W].
- zombie_delay_spawn  out  NUM_ZOMBIES*DELAY_W  packed likewise.

Behaviour:
- Reset (async assert, sync release):
  - state=TITLE; level=0; event_screen=0; new_level=0.
  - All speed/delay fields 0; armed=0; play_q=0; intermission counter 0.
- play_rise = Play & ~play_q; play_q is registered every cycle.
- All outputs are registered, with one cycle of latency from the state transition.
- States: TITLE, LEVEL, INTERMISSION, WIN, GAME_OVER (plus PAUSED under option).
- TITLE: on play_rise → LEVEL with level=1.
- LEVEL:
  - Priority 1: player_health==0 → GAME_OVER.
  - Priority 2: armed & enemies_remaining==0 → INTERMISSION if level<NUM_LEVELS, else WIN.
  - Health==0 and clear in the same cycle → GAME_OVER.
- armed:
  - Cleared on every LEVEL entry.
  - Set when enemies_remaining!=0 while in LEVEL.
  - Prevents instant clear while the spawner reloads.
- INTERMISSION:
  - Counter loads INTERMISSION_CYCLES-1 on entry and decrements.
  - At 0 → LEVEL with level+1.
  - Health input is ignored here.
- WIN: play_rise → TITLE.
- GAME_OVER: play_rise → LEVEL with level=1 (retry). No automatic exit.
- new_level = 1 for exactly the first cycle the registered state is LEVEL after a transition into it.
- Config fields are loaded on LEVEL entry and held through LEVEL; they are 0 in every other state.
  - Delay of zombie z: d = BASE_DELAY + z*STAGGER − (level−1)*DELAY_STEP.
    - Computed signed, at least DELAY_W+4 bits.
    - If d<MIN_DELAY use MIN_DELAY; if d>2^DELAY_W−1 saturate.
  - Speed of zombie z: s = 1 + ((level−1)>>SPEED_SHIFT) + (z==NUM_ZOMBIES−1 ? 1 : 0), saturated to SPEED_W.
- Reset asserted mid-level or mid-intermission returns to TITLE immediately; no pending pulse survives.
- Play held high across a transition does not retrigger; it must fall and rise again.

Optional Feature:
- Macro: GAME_LEVEL_SEQUENCER_PAUSE_EN.
- With it defined:
  - Extra input pause (1 bit); only its rising edge acts.
  - In LEVEL, pause_rise → PAUSED.
    - event_screen=5; level and config fields held.
    - Health and enemy inputs are ignored.
  - In PAUSED, pause_rise → LEVEL with no new_level pulse and armed preserved.
  - pause is ignored in all other states.
- Without it: no pause port, no PAUSED state, event_screen never 5.

Test Plan:
- Reset, then a Play pulse → next cycle event_screen=1, level=1, new_level=1 for one cycle. Config outputs (z0,z1,z2):
  - delays 100, 200, 300.
  - speeds 1, 1, 2.
- In level 1, enemies_remaining held 0 from entry (never armed) → stays in LEVEL; set to 2 then 0 → INTERMISSION (event_screen=4).
- Run with INTERMISSION_CYCLES=4 → exactly 4 cycles at event_screen=4, then level=2, new_level pulse.
- Drive to level 10 → delays 20 (clamped), 110, 210; speeds 3, 3, 4. Then clear → WIN (2). Play rise → TITLE (0).
- In LEVEL, player_health=0 and enemies_remaining=0 (armed) in the same cycle → GAME_OVER (3). Play held high → no change; Play re-rise → level=1.
- Reset_n pulsed low mid-intermission → outputs immediately 0/TITLE. With PAUSE_EN: pause rise → event_screen=5, config held; second rise → event_screen=1, no new_level.
